// File: rtl/score_digit_ctrl_pkg.sv
// score_pkg: shared types and constants for the score digit controller.
// Contents: default digit count, BCD nibble and digit-array types,
// controller state enum, renderer field width and the add-3 helper.
package score_pkg;
  localparam int NUM_DIGITS_DEF = 4;
  localparam int DIGIT_FIELD_W = 12;
  typedef logic [3:0] bcd_t;
  typedef bcd_t [NUM_DIGITS_DEF-1:0] digits_t;
  typedef enum logic {IDLE, CONVERT} ctrl_state_t;
  function automatic bcd_t add3(input bcd_t n);
    return n >= 4'd5 ? n + 4'd3 : n;
  endfunction
endpackage

// File: rtl/score_digit_ctrl_if.sv
// score_digit_ctrl_if: game-logic / renderer bus of the score digit controller.
// master (game side): drives i_add_valid, i_add_amount, i_clear, i_v_sync.
// slave (controller): drives o_add_ready, o_score, o_digit_value, o_digit_en,
// o_busy, o_pending.
interface score_digit_ctrl_if #(
  parameter int NUM_DIGITS = 4,
  parameter int SCORE_W = 14
);
  import score_pkg::*;
  logic i_add_valid;
  logic [7:0] i_add_amount;
  logic o_add_ready;
  logic i_clear;
  logic i_v_sync;
  logic [SCORE_W-1:0] o_score;
  logic [NUM_DIGITS*DIGIT_FIELD_W-1:0] o_digit_value;
  logic [NUM_DIGITS-1:0] o_digit_en;
  logic o_busy;
  logic o_pending;
  modport master(output i_add_valid, i_add_amount, i_clear, i_v_sync,
                 input o_add_ready, o_score, o_digit_value, o_digit_en, o_busy, o_pending);
  modport slave(input i_add_valid, i_add_amount, i_clear, i_v_sync,
                output o_add_ready, o_score, o_digit_value, o_digit_en, o_busy, o_pending);
endinterface

// File: rtl/score_digit_ctrl_bin2bcd_seq.sv
// bin2bcd_seq: sequential double-dabble, one fused add-3 + shift per cycle.
// Ports: clk, rst (async, active high); start loads value; restart reloads
// zero and aborts any conversion in flight; done pulses during the final
// step, with bcd carrying that step's result in the same cycle.
module bin2bcd_seq
  import score_pkg::*;
#(
  parameter int SCORE_W = 14,
  parameter int NUM_DIGITS = 4
) (
  input  logic clk,
  input  logic rst,
  input  logic start,
  input  logic restart,
  input  logic [SCORE_W-1:0] value,
  output logic done,
  output logic [4*NUM_DIGITS-1:0] bcd
);
  localparam int CW = $clog2(SCORE_W + 1);
  logic [SCORE_W-1:0] sh;
  logic [4*NUM_DIGITS-1:0] acc, adj;
  logic [CW-1:0] cnt;
  logic busy, last;
  for (genvar d = 0; d < NUM_DIGITS; d++) begin : g_adj
    assign adj[4*d +: 4] = add3(acc[4*d +: 4]);
  end
  // The top nibble's carry-out is dropped: the value never exceeds NUM_DIGITS digits.
  assign bcd = {adj[4*NUM_DIGITS-2:0], sh[SCORE_W-1]};
  assign last = busy && cnt == CW'(SCORE_W - 1);
  assign done = last && !restart;
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      sh <= '0;
      acc <= '0;
      cnt <= '0;
      busy <= 1'b0;
    end else if (start || restart) begin
      sh <= restart ? '0 : value;
      acc <= '0;
      cnt <= '0;
      busy <= 1'b1;
    end else if (busy) begin
      sh <= sh << 1;
      acc <= bcd;
      cnt <= cnt + 1'b1;
      busy <= !last;
    end
endmodule

// File: rtl/score_digit_ctrl.sv
// score_digit_ctrl: owns the score, converts it to BCD and hands digits to renderers on v_sync.
// Ports: i_clk, i_rst (async, active high); bus (slave modport) carries the
// add handshake, clear, v_sync, score, packed 12-bit digit fields, digit
// enables, busy and pending.
// Macro SCORE_LEADING_ZERO_BLANK_EN: blank digits above the most significant
// nonzero one (digit 0 always on); undefined, all digits stay enabled.
module score_digit_ctrl
  import score_pkg::*;
#(
  parameter int NUM_DIGITS = NUM_DIGITS_DEF,
  parameter int SCORE_W = 14,
  parameter int MAX_SCORE = 9999
) (
  input logic i_clk,
  input logic i_rst,
  score_digit_ctrl_if.slave bus
);
  localparam int BW = 4 * NUM_DIGITS;
`ifdef SCORE_LEADING_ZERO_BLANK_EN
  localparam logic [NUM_DIGITS-1:0] EN_RST = NUM_DIGITS'(1);
`else
  localparam logic [NUM_DIGITS-1:0] EN_RST = '1;
`endif
  ctrl_state_t state, state_nxt;
  logic accept, conv_done, vs_q, vs_rise, pend;
  logic [SCORE_W:0] sum;
  logic [SCORE_W-1:0] score, score_nxt;
  logic [BW-1:0] conv_bcd, pend_bcd, disp_bcd;
  logic [NUM_DIGITS-1:0] mask, pend_en, disp_en;
  assign accept = bus.i_add_valid && bus.o_add_ready;
  // One extra bit so the sum cannot wrap before saturation.
  assign sum = {1'b0, score} + (SCORE_W+1)'(bus.i_add_amount);
  assign score_nxt = sum > (SCORE_W+1)'(MAX_SCORE) ? SCORE_W'(MAX_SCORE) : sum[SCORE_W-1:0];
  assign vs_rise = bus.i_v_sync && !vs_q;
  bin2bcd_seq #(.SCORE_W(SCORE_W), .NUM_DIGITS(NUM_DIGITS)) u_conv (
    .clk(i_clk),
    .rst(i_rst),
    .start(accept),
    .restart(bus.i_clear),
    .value(score_nxt),
    .done(conv_done),
    .bcd(conv_bcd)
  );
  always_ff @(posedge i_clk or posedge i_rst)
    if (i_rst) state <= IDLE;
    else state <= state_nxt;
  always_comb
    state_nxt = state == IDLE ? ((accept || bus.i_clear) ? CONVERT : IDLE)
                              : (conv_done ? IDLE : CONVERT);
  always_comb begin
    bus.o_add_ready = state == IDLE && !bus.i_clear;
    bus.o_busy = state == CONVERT;
  end
  always_ff @(posedge i_clk or posedge i_rst)
    if (i_rst) score <= '0;
    else if (bus.i_clear) score <= '0;
    else if (accept) score <= score_nxt;
  for (genvar d = 0; d < NUM_DIGITS; d++) begin : g_digit
`ifdef SCORE_LEADING_ZERO_BLANK_EN
    assign mask[d] = d == 0 || (|conv_bcd[BW-1:4*d]);
`else
    assign mask[d] = 1'b1;
`endif
    assign bus.o_digit_value[DIGIT_FIELD_W*d +: DIGIT_FIELD_W] =
      {(DIGIT_FIELD_W-4)'(0), disp_bcd[4*d +: 4]};
  end
  // A result completing on a vs_rise edge sits in the buffer until the next rise.
  always_ff @(posedge i_clk or posedge i_rst)
    if (i_rst) begin
      vs_q <= 1'b0;
      pend <= 1'b0;
      pend_bcd <= '0;
      pend_en <= EN_RST;
      disp_bcd <= '0;
      disp_en <= EN_RST;
    end else begin
      vs_q <= bus.i_v_sync;
      if (vs_rise && pend) begin
        disp_bcd <= pend_bcd;
        disp_en <= pend_en;
      end
      if (conv_done) begin
        pend_bcd <= conv_bcd;
        pend_en <= mask;
      end
      pend <= conv_done || (pend && !vs_rise);
    end
  assign bus.o_score = score;
  assign bus.o_pending = pend;
  assign bus.o_digit_en = disp_en;
endmodule

// File: tb/tb_score_digit_ctrl.sv
// tb_score_digit_ctrl: self-checking bench for score_digit_ctrl against a cycle reference model.
module tb_score_digit_ctrl;
  import score_pkg::*;
  localparam int N = 4;
  localparam int W = 14;
  localparam int MAX = 9999;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  score_digit_ctrl_if #(.NUM_DIGITS(N), .SCORE_W(W)) bus ();
  score_digit_ctrl #(.NUM_DIGITS(N), .SCORE_W(W), .MAX_SCORE(MAX)) dut (
    .i_clk(clk),
    .i_rst(rst),
    .bus(bus)
  );

  int tests = 0;
  int fails = 0;

  // Reference model: integer score, cycles left in the conversion, the value
  // being converted, the pending buffer value and the displayed value.
  int m_score, m_conv, m_left, m_pbuf, m_disp;
  bit m_pend, m_vsq, m_acc;
  bit vsl;

  typedef struct {
    bit clr;
    int amt;
    int score;
    logic [15:0] bcd;
    logic [3:0] en;
  } vec_t;
  vec_t vecs[8];

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic logic [47:0] dv_of(input int v);
    logic [47:0] r;
    int p;
    r = '0;
    p = 1;
    for (int d = 0; d < N; d++) begin
      r[12*d +: 12] = 12'((v / p) % 10);
      p = p * 10;
    end
    return r;
  endfunction

  function automatic logic [3:0] en_of(input int v);
    logic [3:0] r;
    int p;
    r = '1;
`ifdef SCORE_LEADING_ZERO_BLANK_EN
    p = 1;
    for (int d = 0; d < N; d++) begin
      r[d] = d == 0 || v >= p;
      p = p * 10;
    end
`else
    p = 0;
`endif
    return r;
  endfunction

  function automatic logic [3:0] vec_en(input logic [3:0] e);
`ifdef SCORE_LEADING_ZERO_BLANK_EN
    return e;
`else
    return 4'hf;
`endif
  endfunction

  task automatic model_reset();
    m_score = 0;
    m_conv = 0;
    m_left = 0;
    m_pbuf = 0;
    m_disp = 0;
    m_pend = 0;
    m_vsq = 0;
    m_acc = 0;
  endtask

  task automatic cyc(input bit clr, input bit vld, input int amt, input bit vs);
    int s;
    bus.i_clear = clr;
    bus.i_add_valid = vld;
    bus.i_add_amount = 8'(amt);
    bus.i_v_sync = vs;
    #1;
    chk("ready", 64'(bus.o_add_ready), 64'(m_left == 0 && !clr));
    @(posedge clk);
    m_acc = vld && m_left == 0 && !clr;
    if (vs && !m_vsq && m_pend) begin
      m_disp = m_pbuf;
      m_pend = 0;
    end
    if (m_left == 1 && !clr) begin
      m_pbuf = m_conv;
      m_pend = 1;
    end
    if (clr) begin
      m_score = 0;
      m_conv = 0;
      m_left = W;
    end else if (m_acc) begin
      s = m_score + (amt & 255);
      m_score = s > MAX ? MAX : s;
      m_conv = m_score;
      m_left = W;
    end else if (m_left > 0) m_left--;
    m_vsq = vs;
    #1;
    chk("score", 64'(bus.o_score), 64'(m_score));
    chk("busy", 64'(bus.o_busy), 64'(m_left > 0));
    chk("pending", 64'(bus.o_pending), 64'(m_pend));
    chk("digits", 64'(bus.o_digit_value), 64'(dv_of(m_disp)));
    chk("digit_en", 64'(bus.o_digit_en), 64'(en_of(m_disp)));
  endtask

  task automatic add(input int amt);
    int n;
    n = 0;
    do begin
      cyc(0, 1, amt, vsl);
      n++;
    end while (!m_acc && n < 50);
    if (!m_acc) chk("add_timeout", 64'(n), 64'(0));
  endtask

  task automatic wait_done();
    int n;
    n = 0;
    while (bus.o_busy && n < 40) begin
      cyc(0, 0, 0, vsl);
      n++;
    end
    if (n >= 40) chk("busy_timeout", 64'(n), 64'(0));
  endtask

  task automatic vs_pulse();
    cyc(0, 0, 0, 1);
    cyc(0, 0, 0, 0);
    vsl = 0;
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    int n;
    vecs[0] = '{1'b0, 37, 37, 16'h0037, 4'b0011};
    vecs[1] = '{1'b0, 200, 237, 16'h0237, 4'b0111};
    vecs[2] = '{1'b1, 0, 0, 16'h0000, 4'b0001};
    vecs[3] = '{1'b0, 40, 40, 16'h0040, 4'b0011};
    vecs[4] = '{1'b0, 255, 295, 16'h0295, 4'b0111};
    vecs[5] = '{1'b0, 255, 550, 16'h0550, 4'b0111};
    vecs[6] = '{1'b0, 255, 805, 16'h0805, 4'b0111};
    vecs[7] = '{1'b0, 200, 1005, 16'h1005, 4'b1111};
    vsl = 0;
    bus.i_clear = 0;
    bus.i_add_valid = 0;
    bus.i_add_amount = 0;
    bus.i_v_sync = 0;
    model_reset();
    #22 rst = 0;
    chk("rst_score", 64'(bus.o_score), 64'(0));
    chk("rst_ready", 64'(bus.o_add_ready), 64'(1));
    chk("rst_busy", 64'(bus.o_busy), 64'(0));
    chk("rst_pending", 64'(bus.o_pending), 64'(0));
    chk("rst_digits", 64'(bus.o_digit_value), 64'(0));
    chk("rst_en", 64'(bus.o_digit_en), 64'(vec_en(4'b0001)));
    vs_pulse();
    chk("vs_digits", 64'(bus.o_digit_value), 64'(0));

    for (int i = 0; i < 8; i++) begin
      if (vecs[i].clr) cyc(1, 0, 0, 0);
      else add(vecs[i].amt);
      n = 0;
      while (!bus.o_pending && n < 40) begin
        cyc(0, 0, 0, 0);
        n++;
      end
      chk("pend_latency", 64'(n), 64'(W));
      vs_pulse();
      chk("vec_score", 64'(bus.o_score), 64'(vecs[i].score));
      for (int d = 0; d < N; d++)
        chk("vec_digit", 64'(bus.o_digit_value[12*d +: 12]), 64'({8'h00, vecs[i].bcd[4*d +: 4]}));
      chk("vec_en", 64'(bus.o_digit_en), 64'(vec_en(vecs[i].en)));
    end

    cyc(1, 0, 0, 0);
    wait_done();
    repeat (39) begin
      add(255);
      wait_done();
    end
    add(45);
    wait_done();
    chk("sat_pre", 64'(bus.o_score), 64'(9990));
    add(25);
    wait_done();
    vs_pulse();
    chk("sat_score", 64'(bus.o_score), 64'(9999));
    chk("sat_digits", 64'(bus.o_digit_value), 64'(48'h009009009009));
    add(1);
    chk("sat_reconvert", 64'(bus.o_busy), 64'(1));
    chk("sat_hold", 64'(bus.o_score), 64'(9999));
    wait_done();

    vs_pulse();
    cyc(1, 0, 0, 0);
    wait_done();
    vs_pulse();
    add(10);
    repeat (4) cyc(0, 0, 0, 0);
    cyc(1, 1, 50, 0);
    chk("clr_score", 64'(bus.o_score), 64'(0));
    n = 0;
    while (bus.o_busy && n < 40) begin
      cyc(0, 0, 0, 0);
      n++;
    end
    chk("clr_busy_len", 64'(n), 64'(W));
    vs_pulse();
    chk("clr_digits", 64'(bus.o_digit_value), 64'(0));
    chk("clr_no_add", 64'(bus.o_score), 64'(0));

    add(7);
    repeat (W - 1) cyc(0, 0, 0, 0);
    cyc(0, 0, 0, 1);
    chk("same_edge_pend", 64'(bus.o_pending), 64'(1));
    chk("same_edge_hold", 64'(bus.o_digit_value), 64'(0));
    cyc(0, 0, 0, 0);
    cyc(0, 0, 0, 1);
    chk("next_frame", 64'(bus.o_digit_value), 64'(48'h7));
    cyc(0, 0, 0, 0);
    add(5);
    wait_done();
    add(6);
    wait_done();
    vs_pulse();
    chk("latest_wins", 64'(bus.o_digit_value), 64'(48'h001008));

    repeat (1500) begin
      if ($urandom_range(0, 7) == 0) vsl = !vsl;
      cyc($urandom_range(0, 39) == 0, $urandom_range(0, 2) == 0, int'($urandom_range(0, 255)), vsl);
    end

    vsl = 0;
    cyc(0, 0, 0, 0);
    wait_done();
    add(100);
    repeat (3) cyc(0, 0, 0, 0);
    rst = 1;
    #2;
    chk("mid_rst_busy", 64'(bus.o_busy), 64'(0));
    chk("mid_rst_score", 64'(bus.o_score), 64'(0));
    chk("mid_rst_pend", 64'(bus.o_pending), 64'(0));
    chk("mid_rst_digits", 64'(bus.o_digit_value), 64'(0));
    rst = 0;
    model_reset();
    repeat (20) cyc(0, 0, 0, 0);
    vs_pulse();

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule

// File: doc/score_digit_ctrl.md
Name: score_digit_ctrl

Overview:
- Owns the player score and sequences the per-digit sprite renderers that draw it.
- Accepts score increments and a clear request, saturates at the display maximum, and converts binary to BCD with a sequential double-dabble.
- Publishes the digit values to the renderers only on a rising edge of v_sync, so a frame never shows a half-updated score.
- Sits between game logic (requesters) and NUM_DIGITS digit renderer instances (value inputs, 12-bit each).

Parameters:
- NUM_DIGITS, 4: number of decimal digits displayed; digit 0 is least significant.
- SCORE_W, 14: binary score width; must satisfy 2**SCORE_W > MAX_SCORE.
- MAX_SCORE, 9999: saturation ceiling; must be at most 10**NUM_DIGITS-1.

Ports:
- i_clk  in  1  system clock.
- i_rst  in  1  asynchronous, active-high reset.
- i_add_valid  in  1  increment request.
- i_add_amount  in  8  unsigned increment, accepted when valid && ready.
- o_add_ready  out  1  high only in IDLE.
- i_clear  in  1  single-cycle pulse; zeroes the score; accepted in any state.
- i_v_sync  in  1  vertical sync, same clock domain; a rising edge marks the frame boundary.
- o_score  out  SCORE_W  current binary score.
- o_digit_value  out  NUM_DIGITS*12  packed; digit d occupies bits [12d+11:12d]; upper 8 bits of each field always 0; low 4 bits are BCD 0..9.
- o_digit_en  out  NUM_DIGITS  per-digit render enable.
- o_busy  out  1  high while in CONVERT.
- o_pending  out  1  a converted result is waiting for the next frame edge.

Behaviour:
- Reset (async, i_rst=1):
  - score=0, o_digit_value=0, o_pending=0, o_busy=0, o_add_ready=1.
  - o_digit_en: all ones without the macro; 1 (digit 0 only) with the macro.
  - v_sync history register=0, state=IDLE.
- States:
  - IDLE -> CONVERT on an accepted add or on i_clear.
  - CONVERT runs exactly SCORE_W cycles (one shift plus a fused add-3 per nibble each cycle), then -> IDLE.
- Add:
  - Accepted at edge k: score <= min(score + i_add_amount, MAX_SCORE), computed at SCORE_W+1 bits so the sum cannot wrap.
  - The converter loads the new score, CONVERT occupies edges k+1..k+SCORE_W, and the pending buffer is written with o_pending=1 at edge k+SCORE_W. o_busy is high over those SCORE_W cycles.
- Clear:
  - Zeroes the score at that edge.
  - In CONVERT it aborts the conversion and restarts it from zero, with full SCORE_W latency again.
  - Clear and add_valid in the same cycle: clear wins; the add is not accepted, because ready is forced low that cycle.
- Saturation:
  - An add applied at score == MAX_SCORE is still accepted, re-converts, and leaves the score unchanged.
- Frame transfer:
  - vs_rise = i_v_sync && !vs_q.
  - On vs_rise with registered o_pending == 1: o_digit_value and o_digit_en <= pending buffer, and o_pending <= 0.
  - If a conversion completes on the same edge as vs_rise, the result waits for the next vs_rise.
  - A newer completion overwrites an untransferred pending result (latest wins).
- CONVERT never drives o_digit_value directly; displayed digits are stable between transfers.
- Reset during CONVERT discards all partial state.

Optional Feature:
- Macro: SCORE_LEADING_ZERO_BLANK_EN.
- Defined: the pending o_digit_en clears every digit above the most significant nonzero digit; digit 0 is always enabled (score 0 gives mask 0001; score 40 gives 0011).
- Undefined: o_digit_en is constant all ones.

Decomposition:
- Package score_pkg:
  - NUM_DIGITS default and the BCD nibble typedef.
  - Packed digit-array typedef (NUM_DIGITS x 4).
  - ctrl state enum {IDLE, CONVERT}.
  - DIGIT_FIELD_W=12 constant.
- One sub-module, bin2bcd_seq:
  - Load/start, SCORE_W-cycle shift engine, done pulse, BCD output.
  - Takes a restart input, used for clear-abort.
- The top holds score, saturation, the handshake, the pending buffer, vsync edge logic and the optional mask.

Test Plan:
- Reset then one v_sync pulse -> o_digit_value all 0, o_pending=0, o_add_ready=1, o_score=0.
- add 37, then 200 after ready -> o_score=237; pending rises exactly 14 cycles after each accept; after the next vs_rise digits = 7,3,2,0.
- Score 9990, add 25 -> o_score=9999; digits 9,9,9,9 after vs_rise; a further add 1 keeps 9999.
- i_clear pulsed in CONVERT cycle 5 of an add -> o_score=0, o_busy stays high 14 more cycles, displayed digits 0 after vs_rise; a simultaneous add_valid is not accepted.
- Completion on the same edge as vs_rise -> o_digit_value unchanged that frame, updated at the next vs_rise; two completions before one vs_rise -> only the latest is displayed.
- With SCORE_LEADING_ZERO_BLANK_EN, scores 0, 40 and 1005 -> o_digit_en 0001, 0011, 1111; without the macro -> 1111 in every case.
